vram_fill_engine: RTL and testbench

VRAM_FILL_ENGINE -- requirements
Module: vram_fill_engine

---
 rtl/vram_fill_engine_pkg.sv | 21 ++
 rtl/fill_pattern_gen.sv | 24 ++
 rtl/vram_fill_engine.sv | 118 +++++++++++
 tb/tb_vram_fill_engine.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_fill_engine_pkg.sv
// Shared GPU definitions for the VRAM fill engine: address/data widths,
// fill-mode encodings and fill FSM state encodings.
package vram_fill_engine_pkg;

    localparam int VRAM_ADDR_WIDTH = 12;
    localparam int VRAM_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        MODE_CONST     = 2'b00,
        MODE_INCR      = 2'b01,
        MODE_CHECKER   = 2'b10,
        MODE_CONST_ALT = 2'b11
    } fill_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01,
        ST_DONE  = 2'b10
    } fill_state_e;

endpackage

// File: rtl/fill_pattern_gen.sv
// Combinational fill data generator: maps (mode, seed value, write offset)
// to the byte written at that offset.
module fill_pattern_gen
    import vram_fill_engine_pkg::*;
#(
    parameter int DATA_WIDTH = VRAM_DATA_WIDTH
) (
    input  fill_mode_e            mode,
    input  logic [DATA_WIDTH-1:0] value,
    input  logic [DATA_WIDTH-1:0] offset,
    output logic [DATA_WIDTH-1:0] data
);

    // NOTE: data gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        data = value;
        case (mode)
            MODE_INCR:    data = value + offset;
            MODE_CHECKER: data = offset[0] ? ~value : value;
            default:      data = value;
        endcase
    end

endmodule

// File: rtl/vram_fill_engine.sv
// VRAM fill engine: writes a CONST/INCR/CHECKER pattern over a wrapping address range.
// Define VRAM_FILL_VBLANK_GATE_EN to permit writes only while in_vblank is high.
module vram_fill_engine
    import vram_fill_engine_pkg::*;
#(
    parameter int ADDR_WIDTH = VRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = VRAM_DATA_WIDTH
) (
    input  logic                  clk_12_5875,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_mode,
    input  logic [ADDR_WIDTH-1:0] cmd_base,
    input  logic [ADDR_WIDTH:0]   cmd_len,
    input  logic [DATA_WIDTH-1:0] cmd_value,
    input  logic                  in_vblank,
    output logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  write_enable,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH:0] OFFSET_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    fill_state_e           state_q, state_d;
    fill_mode_e            mode_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH:0]   len_q;
    logic [DATA_WIDTH-1:0] value_q;
    logic [ADDR_WIDTH:0]   offset_q, offset_d, offset_next;
    logic [ADDR_WIDTH-1:0] addr_hold_q;
    logic [DATA_WIDTH-1:0] data_hold_q;
    logic                  ready_en_q;
    logic                  write_permit;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

`ifdef VRAM_FILL_VBLANK_GATE_EN
    assign write_permit = in_vblank;
`else
    // in_vblank has no influence when the gate is not built in.
    assign write_permit = 1'b1 | in_vblank;
`endif

    // ready_en_q keeps cmd_ready low until the first edge after reset releases.
    assign cmd_ready    = (state_q == ST_IDLE) && ready_en_q;
    assign accept       = cmd_valid && cmd_ready;
    assign busy         = (state_q != ST_IDLE);
    assign done         = (state_q == ST_DONE);
    assign write_enable = (state_q == ST_WRITE) && write_permit;
    assign offset_next  = offset_q + OFFSET_ONE;
    assign wr_addr      = base_q + offset_q[ADDR_WIDTH-1:0];

    fill_pattern_gen #(.DATA_WIDTH(DATA_WIDTH)) u_pattern_gen (
        .mode   (mode_q),
        .value  (value_q),
        .offset (DATA_WIDTH'(offset_q)),
        .data   (wr_data)
    );

    // The write port shows the live write when enabled, else the last write issued.
    assign address = write_enable ? wr_addr : addr_hold_q;
    assign data    = write_enable ? wr_data : data_hold_q;

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    offset_d = '0;
                    state_d  = (cmd_len == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (write_enable) begin
                    offset_d = offset_next;
                    if (offset_next == len_q) state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_12_5875 or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            offset_q    <= '0;
            ready_en_q  <= 1'b0;
            mode_q      <= MODE_CONST;
            base_q      <= '0;
            len_q       <= '0;
            value_q     <= '0;
            addr_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            ready_en_q <= 1'b1;
            if (accept) begin
                mode_q  <= fill_mode_e'(cmd_mode);
                base_q  <= cmd_base;
                len_q   <= cmd_len;
                value_q <= cmd_value;
            end
            if (write_enable) begin
                addr_hold_q <= wr_addr;
                data_hold_q <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_vram_fill_engine.sv
// Self-checking bench for vram_fill_engine: queue-based write model checked every
// cycle, plus directed fills with hand-computed literal expectations.
module tb_vram_fill_engine;

    localparam int AW = 12;
    localparam int DW = 8;
`ifdef VRAM_FILL_VBLANK_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_mode;
    logic [AW-1:0] cmd_base;
    logic [AW:0]   cmd_len;
    logic [DW-1:0] cmd_value;
    logic          in_vblank;
    logic [DW-1:0] data;
    logic [AW-1:0] address;
    logic          write_enable;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    vram_fill_engine #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_12_5875  (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_mode     (cmd_mode),
        .cmd_base     (cmd_base),
        .cmd_len      (cmd_len),
        .cmd_value    (cmd_value),
        .in_vblank    (in_vblank),
        .data         (data),
        .address      (address),
        .write_enable (write_enable),
        .busy         (busy),
        .done         (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        int            c;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          vb;
    } log_t;

    wr_t           exp_q[$];
    bit            m_done_due = 1'b0;
    bit            m_ready_en = 1'b0;
    logic [AW-1:0] m_last_a   = '0;
    logic [DW-1:0] m_last_d   = '0;
    int            cyc        = 0;

    function automatic logic [DW-1:0] pattern(input int mode, input logic [DW-1:0] v, input int i);
        case (mode)
            1:       return v + DW'(i);
            2:       return i[0] ? ~v : v;
            default: return v;
        endcase
    endfunction

    function automatic bit permit();
        return GATED ? in_vblank : 1'b1;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // A command becomes a list of pending writes; each permitted cycle retires one,
    // and the cycle after the list empties is the single done cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            m_done_due = 1'b0;
            m_ready_en = 1'b0;
            m_last_a   = '0;
            m_last_d   = '0;
        end else begin
            if (m_done_due) begin
                m_done_due = 1'b0;
            end else if (exp_q.size() > 0) begin
                if (permit()) begin
                    wr_t w;
                    w = exp_q.pop_front();
                    m_last_a = w.a;
                    m_last_d = w.d;
                    if (exp_q.size() == 0) m_done_due = 1'b1;
                end
            end else if (m_ready_en && cmd_valid) begin
                for (int i = 0; i < int'(cmd_len); i++)
                    exp_q.push_back('{a: cmd_base + AW'(i), d: pattern(int'(cmd_mode), cmd_value, i)});
                if (cmd_len == '0) m_done_due = 1'b1;
            end
            m_ready_en = 1'b1;
        end
    end

    // ---------------- per-cycle compare and logging ----------------
    log_t wr_log[$];
    int   done_log[$];
    int   busy_cnt = 0;
    bit   exp_we;
    bit   exp_idle;

    always @(negedge clk) begin
        exp_idle = (exp_q.size() == 0) && !m_done_due;
        exp_we   = (exp_q.size() > 0) && permit();
        check("write_enable", write_enable, exp_we);
        if (exp_we) begin
            check("address", address, exp_q[0].a);
            check("data", data, exp_q[0].d);
        end else begin
            check("address_hold", address, m_last_a);
            check("data_hold", data, m_last_d);
        end
        check("busy", busy, !exp_idle);
        check("done", done, m_done_due);
        check("cmd_ready", cmd_ready, exp_idle && m_ready_en && !rst);
        if (write_enable) wr_log.push_back('{c: cyc + 1, a: address, d: data, vb: in_vblank});
        if (done) done_log.push_back(cyc + 1);
        if (busy) busy_cnt++;
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_logs();
        wr_log.delete();
        done_log.delete();
        busy_cnt = 0;
    endtask

    // Returns the acceptance edge number n (writes are expected from cycle n+1).
    task automatic send(input logic [1:0] m, input logic [AW-1:0] b, input logic [AW:0] l,
                        input logic [DW-1:0] v, output int n);
        int waited = 0;
        while (cmd_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            #1;
            waited++;
        end
        if (waited >= 100) check("send_ready_timeout", 32'd0, 32'd1);
        cmd_valid = 1'b1;
        cmd_mode  = m;
        cmd_base  = b;
        cmd_len   = l;
        cmd_value = v;
        @(posedge clk);
        #1;
        n = cyc;
        cmd_valid = 1'b0;
        cmd_mode  = 2'($urandom);
        cmd_base  = AW'($urandom);
        cmd_len   = (AW + 1)'($urandom);
        cmd_value = DW'($urandom);
    endtask

    task automatic wait_done(input int cnt, input int bound, input string name);
        for (int i = 0; i < bound && done_log.size() < cnt; i++) begin
            @(negedge clk);
            #1;
        end
        check(name, done_log.size() >= cnt, 1'b1);
        @(negedge clk);
        #1;
    endtask

    // ---------------- directed tests ----------------
    logic [AW-1:0] t2_a[4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
    logic [DW-1:0] t2_d[4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    logic [DW-1:0] t3_d[4] = '{8'h55, 8'hAA, 8'h55, 8'hAA};
    int            t6_c[4];

    initial begin
        int n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_mode  = 2'b00;
        cmd_base  = '0;
        cmd_len   = '0;
        cmd_value = '0;
        in_vblank = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", cmd_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_we", write_enable, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_release", cmd_ready, 1'b1);

        // CONST fill
        clear_logs();
        send(2'b00, 12'h000, 13'd8, 8'h0F, n);
        wait_done(1, 50, "const_done_seen");
        check("const_count", wr_log.size(), 8);
        for (int i = 0; i < 8; i++) if (i < wr_log.size()) begin
            check("const_cycle", wr_log[i].c, n + 1 + i);
            check("const_addr", wr_log[i].a, i);
            check("const_data", wr_log[i].d, 8'h0F);
        end
        if (done_log.size() > 0) check("const_done_cycle", done_log[0], n + 9);

        // INCR fill across the address wrap
        clear_logs();
        send(2'b01, 12'hFFE, 13'd4, 8'hFE, n);
        wait_done(1, 50, "incr_done_seen");
        check("incr_count", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) if (i < wr_log.size()) begin
            check("incr_addr", wr_log[i].a, t2_a[i]);
            check("incr_data", wr_log[i].d, t2_d[i]);
        end

        // CHECKER fill
        clear_logs();
        send(2'b10, 12'h800, 13'd4, 8'h55, n);
        wait_done(1, 50, "checker_done_seen");
        check("checker_count", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) if (i < wr_log.size()) begin
            check("checker_addr", wr_log[i].a, 12'h800 + i);
            check("checker_data", wr_log[i].d, t3_d[i]);
        end

        // Zero-length command
        clear_logs();
        send(2'b11, 12'h123, 13'd0, 8'h99, n);
        wait_done(1, 20, "len0_done_seen");
        check("len0_writes", wr_log.size(), 0);
        if (done_log.size() > 0) check("len0_done_cycle", done_log[0], n + 1);
        check("len0_busy_cycles", busy_cnt, 1);

        // cmd_valid held through DONE: second command taken on the first IDLE cycle
        clear_logs();
        cmd_valid = 1'b1;
        cmd_mode  = 2'b00;
        cmd_base  = 12'h300;
        cmd_len   = 13'd2;
        cmd_value = 8'h77;
        @(posedge clk);
        #1;
        n = cyc;
        repeat (4) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done(2, 30, "held_done_seen");
        check("held_count", wr_log.size(), 4);
        if (wr_log.size() == 4) begin
            check("held_w0", wr_log[0].c, n + 1);
            check("held_w1", wr_log[1].c, n + 2);
            check("held_w2", wr_log[2].c, n + 5);
            check("held_w3", wr_log[3].c, n + 6);
        end
        if (done_log.size() == 2) begin
            check("held_done0", done_log[0], n + 3);
            check("held_done1", done_log[1], n + 7);
        end

        // Reset abort after the third write of a 16-write fill
        clear_logs();
        send(2'b01, 12'h100, 13'd16, 8'h20, n);
        for (int i = 0; i < 40 && wr_log.size() < 3; i++) begin
            @(negedge clk);
            #1;
        end
        check("abort_third_write_seen", wr_log.size() >= 3, 1'b1);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_we", write_enable, 1'b0);
        check("abort_addr", address, 12'h000);
        check("abort_data", data, 8'h00);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_ready", cmd_ready, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ready_release", cmd_ready, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        check("abort_no_done", done_log.size(), 0);
        check("abort_writes", wr_log.size(), 3);

        // in_vblank toggling every 2 cycles
        clear_logs();
        fork
            repeat (20) begin
                repeat (2) @(posedge clk);
                #1;
                in_vblank = ~in_vblank;
            end
        join_none
        send(2'b01, 12'h040, 13'd4, 8'h30, n);
        wait_done(1, 40, "vblank_done_seen");
        check("vblank_count", wr_log.size(), 4);
        for (int i = 0; i < 4; i++) if (i < wr_log.size()) begin
            check("vblank_addr", wr_log[i].a, 12'h040 + i);
            check("vblank_data", wr_log[i].d, 8'h30 + i);
            if (GATED) check("vblank_level", wr_log[i].vb, 1'b1);
            else check("ungated_cycle", wr_log[i].c, n + 1 + i);
        end
        if (wr_log.size() == 4 && done_log.size() > 0)
            check("vblank_done_after_last", done_log[0], wr_log[3].c + 1);
        wait fork;
        in_vblank = 1'b1;

        // Full-size fill: 2^AW writes with wrap
        clear_logs();
        send(2'b01, 12'h010, 13'h1000, 8'h10, n);
        wait_done(1, 5000, "full_done_seen");
        check("full_count", wr_log.size(), 4096);
        if (wr_log.size() == 4096) begin
            check("full_first_addr", wr_log[0].a, 12'h010);
            check("full_last_addr", wr_log[4095].a, 12'h00F);
            check("full_last_data", wr_log[4095].d, 8'h0F);
        end
        if (done_log.size() > 0) check("full_done_cycle", done_log[0], n + 4097);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
